// File: rtl/alu_result_buffer.sv
// Small FIFO that captures registered ALU results and flags one cycle after issue,
// with saturating drop counter and sticky overflow indication.
module alu_result_buffer #(
  parameter int NUMBITS = 16,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic [NUMBITS-1:0]       alu_result,
  input  logic                     alu_carryout,
  input  logic                     alu_overflow,
  input  logic                     alu_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUMBITS-1:0]       out_result,
  output logic                     out_carry,
  output logic                     out_overflow,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     sticky_ovf,
  input  logic                     sticky_clr,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = NUMBITS + 3;

  logic          cap_en;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic          push;
  logic          pop;
  logic          drop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A full buffer still accepts a capture when the head leaves in the same cycle.
  assign pop  = !empty && out_ready;
  assign push = cap_en && (!full || pop);
  assign drop = cap_en && full && !pop;

  assign head         = mem[rd_ptr];
  assign out_valid    = !empty;
  assign out_result   = empty ? '0   : head[EW-1:3];
  assign out_carry    = empty ? 1'b0 : head[2];
  assign out_overflow = empty ? 1'b0 : head[1];
  assign out_zero     = empty ? 1'b0 : head[0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {alu_result, alu_carryout, alu_overflow, alu_zero};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cap_en     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      sticky_ovf <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      cap_en <= issue_valid;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      // Overflow set takes priority over a same-cycle clear, dropped captures included.
      if (cap_en && alu_overflow) sticky_ovf <= 1'b1;
      else if (sticky_clr)        sticky_ovf <= 1'b0;
    end
  end

endmodule
